// File: rtl/fwft_lane_fifo_if.sv
// rtl/fwft_lane_fifo_if.sv - handshake bundle for fwft_lane_fifo
//
// Groups the write beat, backpressure, head/pop and status signals.
// slave  : the FIFO side (consumes D/D_VALID/RD_EN, drives everything else)
// master : the environment side (upstream writer plus downstream reader)
interface fwft_lane_fifo_if #(
   parameter int LANES = 8,
   parameter int W     = 64,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [LANES-1:0][W-1:0] D;
   logic                    D_VALID;
   logic                    D_BP;
   logic [LANES-1:0][W-1:0] FIFO_Q;
   logic                    FIFO_VALID;
   logic                    RD_EN;
   logic [CW-1:0]           COUNT;
   logic                    OVERFLOW;
   logic [CW-1:0]           PEAK;

   modport master (
      output D, D_VALID, RD_EN,
      input  D_BP, FIFO_Q, FIFO_VALID, COUNT, OVERFLOW, PEAK
   );

   modport slave (
      input  D, D_VALID, RD_EN,
      output D_BP, FIFO_Q, FIFO_VALID, COUNT, OVERFLOW, PEAK
   );
endinterface

// File: rtl/fwft_lane_fifo.sv
// rtl/fwft_lane_fifo.sv - first-word-fall-through FIFO of multi-lane beats
//
// Each entry is one beat of LANES words of W bits. The head entry is shown
// combinationally on FIFO_Q whenever FIFO_VALID is high; RD_EN pops it.
//
// Ports:
//   CLK              clock, rising edge
//   RST              synchronous reset, active-high
//   bus.D            write beat
//   bus.D_VALID      write request (accepted unless full without a pop)
//   bus.D_BP         registered backpressure, high once BP_SLACK or fewer
//                    entries remain free
//   bus.FIFO_Q       head entry
//   bus.FIFO_VALID   head entry valid
//   bus.RD_EN        pop request (ignored while empty)
//   bus.COUNT        registered occupancy, 0..DEPTH
//   bus.OVERFLOW     sticky, a write was dropped
//   bus.PEAK         occupancy high-watermark
//
// Optional feature: define FWFT_LANE_FIFO_PEAK_EN to build the PEAK
// watermark register; otherwise PEAK is tied to zero.
module fwft_lane_fifo #(
   parameter int LANES    = 8,
   parameter int W        = 64,
   parameter int DEPTH    = 16,
   parameter int BP_SLACK = 4
) (
   input  logic                CLK,
   input  logic                RST,
   fwft_lane_fifo_if.slave     bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] BP_LVL = CW'(DEPTH - BP_SLACK);

   typedef logic [LANES-1:0][W-1:0] beat_t;

   beat_t         mem_q [DEPTH];

   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          bp_q,     bp_d;
   logic          ovf_q,    ovf_d;

   logic          empty;
   logic          full;
   logic          pop;
   logic          wr;

   // Pointers carry one extra bit: equal addresses with differing MSBs
   // means the pointers are a full lap apart.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop      = bus.RD_EN && !empty;
      // A pop frees the head slot in the same edge, so a full FIFO can
      // still take a beat while it is being read.
      wr       = bus.D_VALID && (!full || pop);
      wr_ptr_d = wr_ptr_q + CW'(wr);
      rd_ptr_d = rd_ptr_q + CW'(pop);
      count_d  = count_q + CW'(wr) - CW'(pop);
      bp_d     = (count_d >= BP_LVL);
      ovf_d    = ovf_q || (bus.D_VALID && !wr);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bp_q     <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         bp_q     <= bp_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; pointers alone define which entries are live.
   always_ff @(posedge CLK) begin
      if (wr && !RST) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.D;
      end
   end

   assign bus.FIFO_Q     = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.FIFO_VALID = (count_q != '0);
   assign bus.COUNT      = count_q;
   assign bus.D_BP       = bp_q;
   assign bus.OVERFLOW   = ovf_q;

`ifdef FWFT_LANE_FIFO_PEAK_EN
   logic [CW-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = (count_d > peak_q) ? count_d : peak_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign bus.PEAK = peak_q;
`else
   assign bus.PEAK = '0;
`endif

endmodule

// File: tb/tb_fwft_lane_fifo.sv
// tb/tb_fwft_lane_fifo.sv - testbench for fwft_lane_fifo
module tb_fwft_lane_fifo;
   localparam int LANES    = 8;
   localparam int W        = 64;
   localparam int DEPTH    = 16;
   localparam int BP_SLACK = 4;
   localparam int CW       = $clog2(DEPTH) + 1;

   typedef logic [LANES-1:0][W-1:0] beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fwft_lane_fifo_if #(.LANES(LANES), .W(W), .DEPTH(DEPTH)) bus ();

   fwft_lane_fifo #(
      .LANES(LANES), .W(W), .DEPTH(DEPTH), .BP_SLACK(BP_SLACK)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   beat_t mq[$];
   bit    m_ovf  = 1'b0;
   bit    m_bp   = 1'b1;
   int    m_peak = 0;

   function automatic int exp_peak();
`ifdef FWFT_LANE_FIFO_PEAK_EN
      return m_peak;
`else
      return 0;
`endif
   endfunction

   function automatic beat_t fill(input int v);
      beat_t b;
      for (int l = 0; l < LANES; l++) b[l] = W'(v * 256 + l);
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      for (int l = 0; l < LANES; l++) b[l] = {$urandom, $urandom};
      return b;
   endfunction

   // Drive one cycle, advance the reference queue at the edge, settle.
   task automatic step(input logic r, input logic dv, input beat_t d, input logic re);
      bit p;
      bit w;
      rst         = r;
      bus.D_VALID = dv;
      bus.D       = d;
      bus.RD_EN   = re;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_bp   = 1'b1;
         m_peak = 0;
      end else begin
         p = re && (mq.size() > 0);
         w = dv && ((mq.size() < DEPTH) || p);
         if (dv && !w) m_ovf = 1'b1;
         if (p) void'(mq.pop_front());
         if (w) mq.push_back(d);
         m_bp = (mq.size() >= DEPTH - BP_SLACK);
         if (mq.size() > m_peak) m_peak = mq.size();
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         checks++;
         if (bus.COUNT !== '0 || bus.FIFO_VALID !== 1'b0 || bus.OVERFLOW !== 1'b0 ||
             bus.D_BP !== 1'b1 || bus.PEAK !== '0) begin
            errors++;
            $display("FAIL reset_state: count=%0d valid=%b ovf=%b bp=%b peak=%0d required 0 0 0 1 0",
                     bus.COUNT, bus.FIFO_VALID, bus.OVERFLOW, bus.D_BP, bus.PEAK);
         end
      end
      step(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (bus.D_BP !== 1'b0) begin
         errors++;
         $display("FAIL reset_bp_release: bp=%b required 0", bus.D_BP);
      end
   endtask

   task automatic test_single();
      beat_t hdr;
      for (int l = 0; l < 3; l++) hdr[l] = {8'h2, 56'h0};
      hdr[3] = {8'h1, 56'h1};
      for (int l = 4; l < 7; l++) hdr[l] = {8'h1, 56'h0};
      hdr[7] = 64'd10;
      step(1'b0, 1'b1, hdr, 1'b0);
      checks++;
      if (bus.FIFO_VALID !== 1'b1 || bus.FIFO_Q !== hdr || bus.COUNT !== CW'(1)) begin
         errors++;
         $display("FAIL single_write: valid=%b count=%0d q=%h required valid=1 count=1 q=%h",
                  bus.FIFO_VALID, bus.COUNT, bus.FIFO_Q, hdr);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (bus.FIFO_VALID !== 1'b0 || bus.COUNT !== '0) begin
         errors++;
         $display("FAIL single_pop: valid=%b count=%0d required 0 0", bus.FIFO_VALID, bus.COUNT);
      end
   endtask

   task automatic test_back_to_back();
      beat_t b[3];
      for (int l = 0; l < 3; l++) b[0][l] = {8'h2, 56'h0};
      b[0][3] = {8'h1, 56'h1};
      for (int l = 4; l < 7; l++) b[0][l] = {8'h1, 56'h0};
      b[0][7] = 64'd10;
      for (int l = 0; l < LANES; l++) b[1][l] = 64'(l + 1);
      b[2] = b[1];
      b[2][0] = 64'd9;
      b[2][1] = 64'h10;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, b[i], 1'b1);
         checks++;
         if (bus.FIFO_VALID !== 1'b1 || bus.FIFO_Q !== b[i] || bus.COUNT !== CW'(1)) begin
            errors++;
            $display("FAIL b2b_beat%0d: valid=%b count=%0d q=%h required valid=1 count=1 q=%h",
                     i, bus.FIFO_VALID, bus.COUNT, bus.FIFO_Q, b[i]);
         end
      end
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (bus.FIFO_VALID !== 1'b0 || bus.COUNT !== '0 || bus.PEAK !== CW'(exp_peak())) begin
         errors++;
         $display("FAIL b2b_end: valid=%b count=%0d peak=%0d required 0 0 %0d",
                  bus.FIFO_VALID, bus.COUNT, bus.PEAK, exp_peak());
      end
   endtask

   task automatic test_fill_overflow();
      int c;
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         step(1'b0, 1'b1, fill(k), 1'b0);
         c = (k > DEPTH) ? DEPTH : k;
         checks++;
         if (bus.D_BP !== (k >= 12) || bus.COUNT !== CW'(c) || bus.OVERFLOW !== (k == 17)) begin
            errors++;
            $display("FAIL fill_w%0d: bp=%b count=%0d ovf=%b required bp=%b count=%0d ovf=%b",
                     k, bus.D_BP, bus.COUNT, bus.OVERFLOW, k >= 12, c, k == 17);
         end
      end
      for (int k = 1; k <= DEPTH; k++) begin
         checks++;
         if (bus.FIFO_VALID !== 1'b1 || bus.FIFO_Q !== fill(k)) begin
            errors++;
            $display("FAIL drain_head%0d: valid=%b q=%h required %h",
                     k, bus.FIFO_VALID, bus.FIFO_Q, fill(k));
         end
         step(1'b0, 1'b0, '0, 1'b1);
         c = DEPTH - k;
         checks++;
         if (bus.COUNT !== CW'(c) || bus.D_BP !== (c >= 12) || bus.OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL drain_r%0d: count=%0d bp=%b ovf=%b required count=%0d bp=%b ovf=1",
                     k, bus.COUNT, bus.D_BP, bus.OVERFLOW, c, c >= 12);
         end
      end
   endtask

   task automatic test_full_rw();
      int seq[$];
      int v;
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b0, 1'b1, fill(100 + k), 1'b0);
         seq.push_back(100 + k);
      end
      for (int j = 0; j < 5; j++) begin
         v = seq.pop_front();
         checks++;
         if (bus.FIFO_Q !== fill(v)) begin
            errors++;
            $display("FAIL full_rw_head%0d: q=%h required %h", j, bus.FIFO_Q, fill(v));
         end
         step(1'b0, 1'b1, fill(200 + j), 1'b1);
         seq.push_back(200 + j);
         checks++;
         if (bus.COUNT !== CW'(DEPTH) || bus.OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL full_rw_c%0d: count=%0d ovf=%b required %0d 0",
                     j, bus.COUNT, bus.OVERFLOW, DEPTH);
         end
      end
      while (seq.size() > 0) begin
         v = seq.pop_front();
         checks++;
         if (bus.FIFO_VALID !== 1'b1 || bus.FIFO_Q !== fill(v)) begin
            errors++;
            $display("FAIL full_rw_drain: valid=%b q=%h required %h", bus.FIFO_VALID, bus.FIFO_Q, fill(v));
         end
         step(1'b0, 1'b0, '0, 1'b1);
      end
      checks++;
      if (bus.FIFO_VALID !== 1'b0 || bus.COUNT !== '0) begin
         errors++;
         $display("FAIL full_rw_empty: valid=%b count=%0d required 0 0", bus.FIFO_VALID, bus.COUNT);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, fill(300 + k), 1'b0);
      checks++;
      if (bus.COUNT !== CW'(5)) begin
         errors++;
         $display("FAIL mid_pre: count=%0d required 5", bus.COUNT);
      end
      step(1'b1, 1'b1, fill(999), 1'b0);
      checks++;
      if (bus.COUNT !== '0 || bus.FIFO_VALID !== 1'b0 || bus.OVERFLOW !== 1'b0 || bus.PEAK !== '0) begin
         errors++;
         $display("FAIL mid_reset: count=%0d valid=%b ovf=%b peak=%0d required 0 0 0 0",
                  bus.COUNT, bus.FIFO_VALID, bus.OVERFLOW, bus.PEAK);
      end
      step(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (bus.COUNT !== '0 || bus.FIFO_VALID !== 1'b0) begin
         errors++;
         $display("FAIL mid_dropped: count=%0d valid=%b required 0 0", bus.COUNT, bus.FIFO_VALID);
      end
   endtask

   task automatic test_random();
      logic r;
      logic dv;
      logic re;
      int   wp;
      int   rp;
      for (int i = 0; i < 3000; i++) begin
         wp = ((i / 250) % 2 == 0) ? 80 : 30;
         rp = 110 - wp;
         r  = ($urandom_range(0, 299) == 0);
         dv = ($urandom_range(0, 99) < wp);
         re = ($urandom_range(0, 99) < rp);
         step(r, dv, rand_beat(), re);
         checks++;
         if (bus.COUNT !== CW'(mq.size()) || bus.FIFO_VALID !== (mq.size() > 0) ||
             bus.D_BP !== m_bp || bus.OVERFLOW !== m_ovf || bus.PEAK !== CW'(exp_peak())) begin
            errors++;
            $display("FAIL rand_status%0d: count=%0d valid=%b bp=%b ovf=%b peak=%0d required %0d %b %b %b %0d",
                     i, bus.COUNT, bus.FIFO_VALID, bus.D_BP, bus.OVERFLOW, bus.PEAK,
                     mq.size(), mq.size() > 0, m_bp, m_ovf, exp_peak());
         end
         if (mq.size() > 0) begin
            checks++;
            if (bus.FIFO_Q !== mq[0]) begin
               errors++;
               $display("FAIL rand_head%0d: q=%h required %h", i, bus.FIFO_Q, mq[0]);
            end
         end
      end
   endtask

   initial begin
      bus.D       = '0;
      bus.D_VALID = 1'b0;
      bus.RD_EN   = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_overflow();
      test_full_rw();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fwft_lane_fifo.md
Name: fwft_lane_fifo

Overview:
Parametrised first-word-fall-through FIFO for multi-lane routing flits. Each entry holds LANES words of W bits, written and read as one beat. It generalises the fixed 8x64 test FIFO with configurable geometry, occupancy reporting, slack-based backpressure and overflow detection. It sits between a router input port and its downstream consumer.

Parameters:
LANES, 8, words per beat
W, 64, bits per lane word
DEPTH, 16, entries; power of two, at least 4
BP_SLACK, 4, free entries left when D_BP asserts; 1 <= BP_SLACK < DEPTH
CW, $clog2(DEPTH)+1, width of COUNT (derived, not overridden)

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
D  in  [LANES-1:0][W-1:0]  write beat
D_VALID  in  1  write request
D_BP  out  1  backpressure to upstream (registered)
FIFO_Q  out  [LANES-1:0][W-1:0]  head entry
FIFO_VALID  out  1  head entry valid
RD_EN  in  1  pop request
COUNT  out  CW  occupancy (registered)
OVERFLOW  out  1  sticky; a write was dropped
PEAK  out  CW  high-watermark (optional feature)

Behaviour:
- Reset, RST high at a clock edge: pointers 0, COUNT=0, FIFO_VALID=0, OVERFLOW=0, PEAK=0, D_BP=1. Storage contents are don't-care and are not cleared. A reset mid-operation discards all entries at that edge.
- D_BP recomputes at the first edge with RST low.
- Storage: register array of DEPTH entries. Read/write pointers are log2(DEPTH)+1 bits. Address wraps naturally; the MSB distinguishes full from empty.
- Write accept: wr = D_VALID && (COUNT<DEPTH || pop). D_BP is advisory. Upstream may keep writing for up to BP_SLACK beats after D_BP rises.
- Pop: pop = RD_EN && FIFO_VALID. RD_EN while empty is ignored and has no side effects.
- FWFT: FIFO_Q = mem[rd_ptr], combinational from storage. FIFO_VALID = (COUNT!=0).
- Write-to-visible latency is 1 cycle: a beat written at edge k appears on FIFO_Q with FIFO_VALID=1 in the cycle after edge k. There is no bypass, so a beat written into an empty FIFO cannot be popped in the same cycle.
- Simultaneous wr and pop: COUNT unchanged. This is legal when full: the head is popped and the new beat is stored.
- COUNT_next = COUNT + wr - pop, range 0..DEPTH.
- D_BP_next = (COUNT_next >= DEPTH-BP_SLACK). D_BP therefore rises at the same edge COUNT reaches the threshold.
- Overflow: D_VALID while full with no pop means the beat is dropped and storage/pointers are unchanged. OVERFLOW is set at that edge and held until RST.
- Ordering: strict FIFO across whole beats. Lanes are never reordered or split.

Optional Feature:
Macro FWFT_LANE_FIFO_PEAK_EN.
- Defined: PEAK is a register updated each edge to max(PEAK, COUNT_next) and cleared only by RST.
- Undefined: PEAK is tied to 0 and no watermark logic is synthesised.

Test Plan:
1. Reset (LANES=8, W=64, DEPTH=16, BP_SLACK=4): hold RST 12 cycles -> COUNT=0, FIFO_VALID=0, OVERFLOW=0, D_BP=1 during reset; D_BP=0 one edge after RST drops.
2. Single write of header beat (lanes 0-2 = {8'h2,56'h0}, lane3 = {8'h1,56'h1}, lanes 4-6 = {8'h1,56'h0}, lane7 = 10) with RD_EN=0 -> next cycle FIFO_VALID=1, FIFO_Q equals beat, COUNT=1. Pulse RD_EN -> FIFO_VALID=0, COUNT=0.
3. Three back-to-back beats with RD_EN held at 1 (header, then 1..8, then lane0=9, lane1=16'h10 with lanes 2-7 unchanged from the previous beat) -> beats emerge in order, each one cycle after its write; COUNT peaks at 1; PEAK=1 when FWFT_LANE_FIFO_PEAK_EN is defined.
4. 17 consecutive writes of values 1..17 with RD_EN=0 -> D_BP=1 from the edge of write 12; COUNT=16 after write 16; write 17 dropped and OVERFLOW=1. Then drain -> reads 1..16 in order, COUNT=0, D_BP=0 once COUNT<12, OVERFLOW still 1.
5. Full FIFO with D_VALID=1 and RD_EN=1 for 5 cycles -> COUNT stays 16, OVERFLOW unchanged, output order continuous with no gaps or duplicates.
6. Reset mid-stream with COUNT=5 and D_VALID=1 at the reset edge -> after the edge COUNT=0, FIFO_VALID=0, OVERFLOW=0, PEAK=0; the beat presented at the reset edge is not stored.
